// File: rtl/uart_msg_ctrl.sv
// UART transmit-side controller: echoes received bytes through a FIFO (loopback)
// or streams a fixed message ROM, pacing every byte on the transmitter's busy flag.
module uart_msg_ctrl #(
  parameter int                          DATA_W     = 8,
  parameter int                          MSG_LEN    = 12,
  parameter logic [MSG_LEN*DATA_W-1:0]   MSG        = "Hello FPGA\r\n",
  parameter int                          FIFO_DEPTH = 16,
  parameter int                          GAP_CYCLES = 160
) (
  input  logic                          clk_uart,
  input  logic                          reset_n,
  input  logic [1:0]                    mode,
  input  logic                          trigger,
  input  logic                          clr_ovf,
  input  logic [DATA_W-1:0]             rxdata,
  input  logic                          rxdata_ok,
  input  logic                          tx_busy,
  output logic [DATA_W-1:0]             txdata,
  output logic                          dataok,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          msg_done,
  output logic [2:0]                    dbg_state
);

  localparam int              AW       = $clog2(FIFO_DEPTH);
  localparam int              CW       = AW + 1;
  localparam int              GW       = $clog2(GAP_CYCLES) + 1;
  localparam logic [7:0]      LAST_IDX = 8'(MSG_LEN - 1);
  localparam logic [GW-1:0]   GAP_LOAD = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SEND      = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_IDLE = 3'd3,
    S_GAP       = 3'd4
  } state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   txdata_q;
  logic                dataok_q;
  logic                msg_done_q;
  logic [7:0]          msg_idx_q;
  logic [GW-1:0]       gap_cnt_q;
  logic                is_msg_q;
  logic                is_rep_q;

  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q;
  logic [AW-1:0]       rd_ptr_q;
  logic [CW-1:0]       count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                fifo_full, fifo_empty, pop, push;

  // Byte 0 of the message is the leftmost byte of MSG.
  function automatic logic [DATA_W-1:0] msg_byte(input logic [7:0] idx);
    logic [MSG_LEN*DATA_W-1:0] sh;
    sh = MSG << (int'(idx) * DATA_W);
    return sh[MSG_LEN*DATA_W-1 -: DATA_W];
  endfunction

  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  // A new byte is only launched once the transmitter reports idle.
  assign pop  = (state_q == S_IDLE) && !tx_busy && (mode == 2'd0) && !fifo_empty;
  assign push = rxdata_ok && (!fifo_full || pop);

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    ovf_d = (ovf_q && !clr_ovf) || (rxdata_ok && !push);
  end

  always_ff @(posedge clk_uart or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset: occupancy is governed entirely by the pointers.
  always_ff @(posedge clk_uart) begin
    if (push) mem_q[wr_ptr_q] <= rxdata;
  end

  // Handshake: dataok is a one-cycle strobe with txdata valid; txdata then stays
  // stable until tx_busy has been seen high and has fallen back low again.
  always_ff @(posedge clk_uart or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      txdata_q   <= '0;
      dataok_q   <= 1'b0;
      msg_done_q <= 1'b0;
      msg_idx_q  <= '0;
      gap_cnt_q  <= '0;
      is_msg_q   <= 1'b0;
      is_rep_q   <= 1'b0;
    end else begin
      dataok_q   <= 1'b0;
      msg_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            txdata_q <= mem_q[rd_ptr_q];
            dataok_q <= 1'b1;
            is_msg_q <= 1'b0;
            state_q  <= S_SEND;
          end else if (!tx_busy && mode == 2'd1) begin
            txdata_q <= msg_byte(msg_idx_q);
            dataok_q <= 1'b1;
            is_msg_q <= 1'b1;
            is_rep_q <= 1'b1;
            state_q  <= S_SEND;
          end else if (!tx_busy && mode == 2'd2 && trigger) begin
            msg_idx_q <= '0;
            txdata_q  <= msg_byte(8'd0);
            dataok_q  <= 1'b1;
            is_msg_q  <= 1'b1;
            is_rep_q  <= 1'b0;
            state_q   <= S_SEND;
          end
        end
        S_SEND:      state_q <= S_WAIT_BUSY;
        S_WAIT_BUSY: if (tx_busy) state_q <= S_WAIT_IDLE;
        S_WAIT_IDLE: begin
          if (!tx_busy) begin
            if (!is_msg_q) begin
              state_q <= S_IDLE;
            end else if (msg_idx_q != LAST_IDX) begin
              msg_idx_q <= msg_idx_q + 8'd1;
              txdata_q  <= msg_byte(msg_idx_q + 8'd1);
              dataok_q  <= 1'b1;
              state_q   <= S_SEND;
            end else begin
              msg_done_q <= 1'b1;
              msg_idx_q  <= '0;
              if (is_rep_q) begin
                gap_cnt_q <= GAP_LOAD;
                state_q   <= S_GAP;
              end else begin
                state_q <= S_IDLE;
              end
            end
          end
        end
        S_GAP: begin
          if (gap_cnt_q == '0) state_q <= S_IDLE;
          else                 gap_cnt_q <= gap_cnt_q - GW'(1);
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign txdata     = txdata_q;
  assign dataok     = dataok_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign msg_done   = msg_done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_msg_ctrl.sv
// Bench for uart_msg_ctrl: transmitter model plus a byte-order scoreboard fed
// from a queue-level view of loopback and message traffic.
module tb_uart_msg_ctrl;
  localparam int DW  = 8;
  localparam int ML  = 12;
  localparam int GAP = 160;

  logic          clk_uart  = 1'b0;
  logic          reset_n   = 1'b0;
  logic [1:0]    mode      = 2'd3;
  logic          trigger   = 1'b0;
  logic          clr_ovf   = 1'b0;
  logic [DW-1:0] rxdata    = '0;
  logic          rxdata_ok = 1'b0;
  logic          tx_busy   = 1'b0;
  logic [DW-1:0] txdata;
  logic          dataok;
  logic [4:0]    fifo_count;
  logic          overflow;
  logic          msg_done;
  logic [2:0]    dbg_state;

  uart_msg_ctrl dut (
    .clk_uart   (clk_uart),
    .reset_n    (reset_n),
    .mode       (mode),
    .trigger    (trigger),
    .clr_ovf    (clr_ovf),
    .rxdata     (rxdata),
    .rxdata_ok  (rxdata_ok),
    .tx_busy    (tx_busy),
    .txdata     (txdata),
    .dataok     (dataok),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .msg_done   (msg_done),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk_uart = ~clk_uart;

  int cyc = 0;
  always @(posedge clk_uart) cyc++;

  // ---------------- scoreboard state ----------------
  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] exp_q[$];
  int            got_cnt = 0;
  int            done_cnt = 0;
  int            last_done_cyc = 0;
  int            last_ok_cyc = 0;
  int            busy_cnt = 0;
  int            busy_len = 10;
  bit            busy_rand = 1'b0;
  bit            force_busy = 1'b0;
  int            proto_err = 0;
  logic [DW-1:0] last_tx = '0;
  bit            prev_dataok = 1'b0;
  bit            prev_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] msg_ch(input int i);
    string s;
    s = "Hello FPGA\r\n";
    return s[i];
  endfunction

  task automatic push_msg();
    for (int i = 0; i < ML; i++) exp_q.push_back(msg_ch(i));
  endtask

  // ---------------- transmitter model + scoreboard ----------------
  always @(negedge clk_uart) begin
    if (!reset_n) begin
      busy_cnt    = 0;
      tx_busy     = 1'b0;
      prev_dataok = 1'b0;
      prev_done   = 1'b0;
    end else begin
      if (busy_cnt > 0 && txdata !== last_tx) proto_err++;
      if (dataok) begin
        if (prev_dataok || busy_cnt > 0) proto_err++;
        got_cnt++;
        last_ok_cyc = cyc;
        if (exp_q.size() == 0) check("spurious_dataok", 32'(exp_q.size()), 32'd1);
        else                   check("tx_byte", {24'd0, txdata}, {24'd0, exp_q.pop_front()});
        last_tx  = txdata;
        busy_cnt = busy_rand ? int'($urandom_range(2, 12)) : busy_len;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      tx_busy = force_busy || (busy_cnt > 0);
      if (msg_done) begin
        if (prev_done) proto_err++;
        done_cnt++;
        last_done_cyc = cyc;
        check("msg_done_after_last", {24'd0, last_tx}, {24'd0, msg_ch(ML - 1)});
      end
      prev_dataok = dataok;
      prev_done   = msg_done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_rx(input logic [DW-1:0] b, input bit expect_out);
    rxdata    = b;
    rxdata_ok = 1'b1;
    if (expect_out) exp_q.push_back(b);
    @(negedge clk_uart);
    rxdata_ok = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || tx_busy) && n < budget) begin
      @(negedge clk_uart);
      n++;
    end
    check({tag, "_drain_timeout"}, (n < budget) ? 32'd1 : 32'd0, 32'd1);
    repeat (3) @(negedge clk_uart);
  endtask

  task automatic wait_got(input string tag, input int target, input int budget);
    int n = 0;
    while (got_cnt < target && n < budget) begin
      @(negedge clk_uart);
      n++;
    end
    check({tag, "_byte_timeout"}, (n < budget) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk_uart);
      n++;
    end
    check({tag, "_done_timeout"}, (n < budget) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_txdata"},     {24'd0, txdata},     32'd0);
    check({tag, "_dataok"},     {31'd0, dataok},     32'd0);
    check({tag, "_fifo_count"}, {27'd0, fifo_count}, 32'd0);
    check({tag, "_overflow"},   {31'd0, overflow},   32'd0);
    check({tag, "_msg_done"},   {31'd0, msg_done},   32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, got %0d bytes", got_cnt);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int g0, d0, gap, n;
    logic [DW-1:0] b;

    repeat (3) @(negedge clk_uart);
    check_reset_outputs("rst");
    reset_n = 1'b1;
    repeat (2) @(negedge clk_uart);

    // Loopback with first-byte latency.
    mode = 2'd0;
    @(negedge clk_uart);
    g0 = got_cnt;
    rxdata = 8'h41; rxdata_ok = 1'b1; exp_q.push_back(8'h41);
    @(negedge clk_uart);
    check("lat_n1_dataok", {31'd0, dataok}, 32'd0);
    rxdata = 8'h42; exp_q.push_back(8'h42);
    @(negedge clk_uart);
    rxdata_ok = 1'b0;
    check("lat_n2_dataok", {31'd0, dataok}, 32'd1);
    check("lat_n2_txdata", {24'd0, txdata}, 32'h41);
    wait_drain("loop", 400);
    check("loop_count", 32'(got_cnt - g0), 32'd2);
    check("loop_fifo_empty", {27'd0, fifo_count}, 32'd0);

    // Overflow while the transmitter is held busy.
    force_busy = 1'b1;
    repeat (2) @(negedge clk_uart);
    for (int i = 0; i < 17; i++) send_rx(8'(i), i < 16);
    check("ovf_fifo_full", {27'd0, fifo_count}, 32'd16);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    force_busy = 1'b0;
    wait_drain("ovf", 1000);
    check("ovf_fifo_empty", {27'd0, fifo_count}, 32'd0);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    clr_ovf = 1'b1;
    @(negedge clk_uart);
    clr_ovf = 1'b0;
    check("ovf_cleared", {31'd0, overflow}, 32'd0);

    // Set and clear of overflow in the same cycle: set wins.
    force_busy = 1'b1;
    repeat (2) @(negedge clk_uart);
    for (int i = 0; i < 16; i++) send_rx(8'($urandom_range(0, 255)), 1'b1);
    clr_ovf = 1'b1;
    send_rx(8'h99, 1'b0);
    clr_ovf = 1'b0;
    check("ovf_set_wins", {31'd0, overflow}, 32'd1);
    clr_ovf = 1'b1;
    @(negedge clk_uart);
    clr_ovf = 1'b0;
    check("ovf_cleared2", {31'd0, overflow}, 32'd0);
    force_busy = 1'b0;
    wait_drain("ovf2", 1000);

    // Repeat message: two passes with the idle gap between them, then halt.
    mode = 2'd1;
    d0 = done_cnt;
    push_msg();
    push_msg();
    wait_done("rep1", d0 + 1, 1000);
    g0 = got_cnt;
    wait_got("rep_restart", g0 + 1, 600);
    gap = last_ok_cyc - last_done_cyc;
    check("rep_gap_in_range", (gap >= GAP && gap <= GAP + 4) ? 32'd1 : 32'd0, 32'd1);
    mode = 2'd3;
    wait_done("rep2", d0 + 2, 1000);
    wait_drain("rep", 400);
    g0 = got_cnt;
    repeat (300) @(negedge clk_uart);
    check("halt_quiet", 32'(got_cnt - g0), 32'd0);

    // One-shot message; a trigger during transmission is ignored.
    mode = 2'd2;
    busy_rand = 1'b1;
    for (int r = 0; r < 3; r++) begin
      g0 = got_cnt;
      d0 = done_cnt;
      push_msg();
      trigger = 1'b1;
      @(negedge clk_uart);
      trigger = 1'b0;
      wait_got("oneshot_mid", g0 + 1 + int'($urandom_range(1, 8)), 600);
      trigger = 1'b1;
      @(negedge clk_uart);
      trigger = 1'b0;
      wait_drain("oneshot", 1000);
      repeat (200) @(negedge clk_uart);
      check("oneshot_bytes", 32'(got_cnt - g0), 32'(ML));
      check("oneshot_done", 32'(done_cnt - d0), 32'd1);
    end

    // Mode switch 1 -> 0 mid-message with a byte waiting in the FIFO.
    busy_rand = 1'b0;
    busy_len  = 10;
    mode = 2'd1;
    g0 = got_cnt;
    d0 = done_cnt;
    push_msg();
    wait_got("switch", g0 + 5, 600);
    mode = 2'd0;
    send_rx(8'h55, 1'b1);
    check("switch_fifo_held", {27'd0, fifo_count}, 32'd1);
    wait_drain("switch", 2000);
    check("switch_done", 32'(done_cnt - d0), 32'd1);
    check("switch_bytes", 32'(got_cnt - g0), 32'(ML + 1));
    check("switch_fifo_empty", {27'd0, fifo_count}, 32'd0);

    // Randomized loopback bursts with random transmitter busy lengths.
    busy_rand = 1'b1;
    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(1, 8));
      for (int i = 0; i < n; i++) begin
        send_rx(8'($urandom_range(0, 255)), 1'b1);
        repeat ($urandom_range(0, 3)) @(negedge clk_uart);
      end
      wait_drain("rand_loop", 1000);
      check("rand_fifo_empty", {27'd0, fifo_count}, 32'd0);
      check("rand_no_ovf", {31'd0, overflow}, 32'd0);
    end

    // Asynchronous reset during WAIT_IDLE with three bytes queued.
    busy_rand = 1'b0;
    busy_len  = 60;
    g0 = got_cnt;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(1, 255));
      send_rx(b, 1'b1);
    end
    repeat (3) @(negedge clk_uart);
    check("pre_rst_fifo", {27'd0, fifo_count}, 32'd3);
    check("pre_rst_sent", 32'(got_cnt - g0), 32'd1);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    exp_q.delete();
    repeat (2) @(negedge clk_uart);
    reset_n  = 1'b1;
    busy_len = 10;
    g0 = got_cnt;
    repeat (50) @(negedge clk_uart);
    check("post_rst_quiet", 32'(got_cnt - g0), 32'd0);
    send_rx(8'h5A, 1'b1);
    wait_drain("post_rst", 400);
    check("post_rst_echo", 32'(got_cnt - g0), 32'd1);

    check("protocol_errors", 32'(proto_err), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
